// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: next-PC select codes, the nop encoding,
// datapath widths and the fetch FSM state type.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int JIDX_W = 26;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush inserts a nop bubble and beats hold;
// hold beats a new load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              load,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [DATA_W-1:0] pc4_d,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] pcPlus4,
  output logic              idValid
);

  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic              vld_p1;

  // IF -> ID stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1 <= NOP_INSTR;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (load && !hold) begin
      instr_p1 <= instr_d;
      pc4_p1   <= pc4_d;
      vld_p1   <= 1'b1;
    end
  end

  assign instruction = instr_p1;
  assign pcPlus4     = pc4_p1;
  assign idValid     = vld_p1;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC, next-PC select and the memory handshake FSM
// feeding if_id_reg. Define FETCH_PERF_CNT_EN to add stall/flush counters.
module fetch_unit
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pcSrc,
  input  logic [DATA_W-1:0] branchAddr,
  input  logic [JIDX_W-1:0] jumpAddr,
  input  logic              IFFlush,
  input  logic              stall,
  output logic              imemReq,
  output logic [DATA_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [DATA_W-1:0] imemData,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] pcPlus4,
  output logic              idValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [DATA_W-1:0] stallCnt,
  output logic [DATA_W-1:0] flushCnt
`endif
);

  fetch_state_t      state, state_nxt;
  logic [DATA_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] hold_buf, hold_nxt;
  logic [DATA_W-1:0] tgt_q, tgt_nxt;
  logic              run;
  logic [DATA_W-1:0] pc_plus4;
  logic              redir;
  logic [DATA_W-1:0] redir_tgt;
  logic              load;
  logic [DATA_W-1:0] load_instr;

  // run keeps the request low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= '0;
      hold_buf <= '0;
      tgt_q    <= '0;
      run      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      hold_buf <= hold_nxt;
      tgt_q    <= tgt_nxt;
      run      <= 1'b1;
    end
  end

  // Jump targets take their region bits from pc+4, not from pc.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    redir     = 1'b0;
    redir_tgt = branchAddr;
    case (pcSrc)
      PCSRC_BRANCH: begin
        redir     = !stall;
        redir_tgt = branchAddr;
      end
      PCSRC_JUMP: begin
        redir     = !stall;
        redir_tgt = {pc_plus4[31:28], jumpAddr, 2'b00};
      end
      PCSRC_SEQ: redir = 1'b0;
      default:   redir = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    hold_nxt   = hold_buf;
    tgt_nxt    = tgt_q;
    load       = 1'b0;
    load_instr = imemData;
    if (run) begin
      case (state)
        FETCH: begin
          if (imemAck) begin
            if (stall) begin
              hold_nxt  = imemData;
              state_nxt = HOLD;
            end else if (redir) begin
              pc_nxt = redir_tgt;
            end else begin
              load   = 1'b1;
              pc_nxt = pc_plus4;
            end
          end else if (redir) begin
            tgt_nxt   = redir_tgt;
            state_nxt = KILL;
          end
        end
        HOLD: begin
          if (!stall) begin
            state_nxt = FETCH;
            if (redir) begin
              pc_nxt = redir_tgt;
            end else begin
              load       = 1'b1;
              load_instr = hold_buf;
              pc_nxt     = pc_plus4;
            end
          end
        end
        KILL: begin
          // A newer redirect while the dead fetch drains replaces the old target.
          if (redir) tgt_nxt = redir_tgt;
          if (imemAck) begin
            pc_nxt    = redir ? redir_tgt : tgt_q;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign imemReq  = run && (state != HOLD);
  assign imemAddr = pc;

  if_id_reg u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (IFFlush),
    .hold        (stall),
    .load        (load),
    .instr_d     (load_instr),
    .pc4_d       (pc_plus4),
    .instruction (instruction),
    .pcPlus4     (pcPlus4),
    .idValid     (idValid)
  );

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall)   stallCnt <= sat_inc(stallCnt);
      if (IFFlush) flushCnt <= sat_inc(flushCnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a transaction-level fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pcSrc;
  logic [31:0] branchAddr;
  logic [25:0] jumpAddr;
  logic        IFFlush;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic [31:0] pcPlus4;
  logic        idValid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Data is only meaningful alongside an ack; otherwise the bus carries junk.
  assign imemData = imemAck ? mem_word(imemAddr) : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pcSrc       (pcSrc),
    .branchAddr  (branchAddr),
    .jumpAddr    (jumpAddr),
    .IFFlush     (IFFlush),
    .stall       (stall),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemAck     (imemAck),
    .imemData    (imemData),
    .instruction (instruction),
    .pcPlus4     (pcPlus4),
    .idValid     (idValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stallCnt    (stallCnt),
    .flushCnt    (flushCnt)
`endif
  );

  task automatic idle_inputs();
    pcSrc = 2'd0; branchAddr = '0; jumpAddr = '0;
    IFFlush = 1'b0; stall = 1'b0; imemAck = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic advance_to(input logic [31:0] target);
    imemAck = 1'b1; stall = 1'b0; pcSrc = 2'd0;
    for (int n = 0; n < 200 && imemAddr !== target; n++) cyc();
    checks++;
    if (imemAddr !== target) begin
      failures++;
      $display("FAIL advance_to addr got=%h want=%h", imemAddr, target);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    imemAck = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imemReq, imemAddr, instruction, pcPlus4, idValid} !== '0) begin
      failures++;
      $display("FAIL reset_outputs req=%b addr=%h instr=%h pc4=%h vld=%b want all zero",
               imemReq, imemAddr, instruction, pcPlus4, idValid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_req got=%b want=0", imemReq);
    end
    @(posedge clk); #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      failures++;
      $display("FAIL first_request req=%b addr=%h want req=1 addr=0", imemReq, imemAddr);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_sequential();
    apply_reset();
    imemAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imemAddr !== 32'(4 * i) || imemReq !== 1'b1) begin
        failures++;
        $display("FAIL seq_addr[%0d] got=%h req=%b want=%h", i, imemAddr, imemReq, 4 * i);
      end
      if (i > 0) begin
        checks++;
        if (pcPlus4 !== 32'(4 * i) || instruction !== mem_word(32'(4 * (i - 1))) || idValid !== 1'b1) begin
          failures++;
          $display("FAIL seq_ifid[%0d] pc4=%h instr=%h vld=%b want pc4=%h instr=%h vld=1",
                   i, pcPlus4, instruction, idValid, 4 * i, mem_word(32'(4 * (i - 1))));
        end
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_ack_delay();
    apply_reset();
    advance_to(32'h10);
    imemAck = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (imemAddr !== 32'h10 || imemReq !== 1'b1 || pcPlus4 !== 32'h10) begin
        failures++;
        $display("FAIL wait_hold[%0d] addr=%h req=%b pc4=%h want addr=10 req=1 pc4=10",
                 k, imemAddr, imemReq, pcPlus4);
      end
      cyc();
    end
    imemAck = 1'b1;
    checks++;
    if (imemAddr !== 32'h10) begin
      failures++;
      $display("FAIL wait_ack_addr got=%h want=10", imemAddr);
    end
    cyc();
    imemAck = 1'b0;
    checks++;
    if (pcPlus4 !== 32'h14 || instruction !== mem_word(32'h10) || idValid !== 1'b1) begin
      failures++;
      $display("FAIL wait_load pc4=%h instr=%h want pc4=14 instr=%h", pcPlus4, instruction, mem_word(32'h10));
    end
    cyc();
    checks++;
    if (pcPlus4 !== 32'h14 || imemAddr !== 32'h14) begin
      failures++;
      $display("FAIL wait_once pc4=%h addr=%h want pc4=14 addr=14", pcPlus4, imemAddr);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    apply_reset();
    advance_to(32'h20);
    stall = 1'b1;
    cyc();
    imemAck = 1'b0;
    checks++;
    if (imemReq !== 1'b0 || pcPlus4 !== 32'h20 || instruction !== mem_word(32'h1C)) begin
      failures++;
      $display("FAIL stall_hold1 req=%b pc4=%h instr=%h want req=0 pc4=20 instr=%h",
               imemReq, pcPlus4, instruction, mem_word(32'h1C));
    end
    cyc();
    checks++;
    if (imemReq !== 1'b0 || pcPlus4 !== 32'h20) begin
      failures++;
      $display("FAIL stall_hold2 req=%b pc4=%h want req=0 pc4=20", imemReq, pcPlus4);
    end
    stall = 1'b0;
    cyc();
    checks++;
    if (instruction !== mem_word(32'h20) || pcPlus4 !== 32'h24 || imemAddr !== 32'h24 || imemReq !== 1'b1) begin
      failures++;
      $display("FAIL stall_release instr=%h pc4=%h addr=%h req=%b want instr=%h pc4=24 addr=24 req=1",
               instruction, pcPlus4, imemAddr, imemReq, mem_word(32'h20));
    end
    idle_inputs();
  endtask

  task automatic test_branch_kill();
    apply_reset();
    advance_to(32'h30);
    imemAck = 1'b0; pcSrc = 2'd1; branchAddr = 32'h100; IFFlush = 1'b1;
    cyc();
    checks++;
    if (instruction !== 32'h0 || idValid !== 1'b0 || imemAddr !== 32'h30 || imemReq !== 1'b1) begin
      failures++;
      $display("FAIL kill_flush instr=%h vld=%b addr=%h req=%b want instr=0 vld=0 addr=30 req=1",
               instruction, idValid, imemAddr, imemReq);
    end
    pcSrc = 2'd0; branchAddr = '0; IFFlush = 1'b0; imemAck = 1'b1;
    cyc();
    checks++;
    if (imemAddr !== 32'h100 || idValid !== 1'b0) begin
      failures++;
      $display("FAIL kill_drop addr=%h vld=%b want addr=100 vld=0", imemAddr, idValid);
    end
    cyc();
    checks++;
    if (instruction !== mem_word(32'h100) || pcPlus4 !== 32'h104 || idValid !== 1'b1) begin
      failures++;
      $display("FAIL kill_resume instr=%h pc4=%h vld=%b want pc4=104", instruction, pcPlus4, idValid);
    end
    idle_inputs();
  endtask

  task automatic test_jump();
    apply_reset();
    advance_to(32'h40);
    pcSrc = 2'd2; jumpAddr = 26'h40;
    cyc();
    checks++;
    if (imemAddr !== 32'h100 || pcPlus4 !== 32'h40) begin
      failures++;
      $display("FAIL jump_target addr=%h pc4=%h want addr=100 pc4=40", imemAddr, pcPlus4);
    end
    pcSrc = 2'd1; branchAddr = 32'h7FFF_FFFC;
    cyc();
    pcSrc = 2'd2; jumpAddr = 26'h123;
    cyc();
    checks++;
    if (imemAddr !== 32'h8000_048C) begin
      failures++;
      $display("FAIL jump_region addr=%h want=8000048c", imemAddr);
    end
    apply_reset();
    advance_to(32'h40);
    pcSrc = 2'd3; branchAddr = 32'h900; jumpAddr = 26'h3FF;
    cyc();
    checks++;
    if (imemAddr !== 32'h44 || pcPlus4 !== 32'h44 || instruction !== mem_word(32'h40)) begin
      failures++;
      $display("FAIL pcsrc3_seq addr=%h pc4=%h want addr=44 pc4=44", imemAddr, pcPlus4);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    apply_reset();
    imemAck = 1'b1; pcSrc = 2'd1; branchAddr = 32'hFFFF_FFFC;
    cyc();
    pcSrc = 2'd0;
    cyc();
    checks++;
    if (pcPlus4 !== 32'h0 || imemAddr !== 32'h0 || instruction !== mem_word(32'hFFFF_FFFC)) begin
      failures++;
      $display("FAIL pc_wrap pc4=%h addr=%h want pc4=0 addr=0", pcPlus4, imemAddr);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    advance_to(32'h80);
    imemAck = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imemReq, imemAddr, instruction, pcPlus4, idValid} !== '0) begin
      failures++;
      $display("FAIL async_reset req=%b addr=%h instr=%h pc4=%h vld=%b want all zero",
               imemReq, imemAddr, instruction, pcPlus4, idValid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++;
    if (imemAddr !== 32'h0 || imemReq !== 1'b1) begin
      failures++;
      $display("FAIL reset_restart addr=%h req=%b want addr=0 req=1", imemAddr, imemReq);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_buf_w, m_doom_t, m_instr, m_pc4, seq, tgt, ld_w, ld_p;
    logic        m_buf_v, m_doom_v, m_vld, redir, ld;
    apply_reset();
    m_pc = '0; m_buf_v = 1'b0; m_buf_w = '0; m_doom_v = 1'b0; m_doom_t = '0;
    m_instr = '0; m_pc4 = '0; m_vld = 1'b0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (imemAddr !== m_pc || imemReq !== !m_buf_v || instruction !== m_instr ||
          pcPlus4 !== m_pc4 || idValid !== m_vld) begin
        failures++;
        $display("FAIL rand[%0d] addr=%h req=%b instr=%h pc4=%h vld=%b want addr=%h req=%b instr=%h pc4=%h vld=%b",
                 c, imemAddr, imemReq, instruction, pcPlus4, idValid,
                 m_pc, !m_buf_v, m_instr, m_pc4, m_vld);
      end
      stall      = ($urandom_range(0, 3) == 0);
      imemAck    = ($urandom_range(0, 2) != 0);
      pcSrc      = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      branchAddr = $urandom & 32'hFFFF_FFFC;
      jumpAddr   = 26'($urandom);
      IFFlush    = ($urandom_range(0, 9) == 0);

      redir = !stall && (pcSrc == 2'd1 || pcSrc == 2'd2);
      seq   = m_pc + 32'd4;
      tgt   = (pcSrc == 2'd1) ? branchAddr : {seq[31:28], jumpAddr, 2'b00};
      ld = 1'b0; ld_w = '0; ld_p = '0;
      if (m_buf_v) begin
        if (!stall) begin
          m_buf_v = 1'b0;
          if (redir) m_pc = tgt;
          else begin ld = 1'b1; ld_w = m_buf_w; ld_p = seq; m_pc = seq; end
        end
      end else if (m_doom_v) begin
        if (redir) m_doom_t = tgt;
        if (imemAck) begin m_pc = m_doom_t; m_doom_v = 1'b0; end
      end else if (imemAck) begin
        if (stall) begin m_buf_v = 1'b1; m_buf_w = mem_word(m_pc); end
        else if (redir) m_pc = tgt;
        else begin ld = 1'b1; ld_w = mem_word(m_pc); ld_p = seq; m_pc = seq; end
      end else if (redir) begin
        m_doom_v = 1'b1; m_doom_t = tgt;
      end
      if (IFFlush) begin m_instr = 32'h0; m_vld = 1'b0; end
      else if (ld) begin m_instr = ld_w; m_pc4 = ld_p; m_vld = 1'b1; end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_ack_delay();
    test_stall();
    test_branch_kill();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
